// File: rtl/prog_ram_loader_pkg.sv
// rtl/prog_ram_loader_pkg.sv - shared processor constants and loader state type
package prog_ram_loader_pkg;

  // Program RAM geometry: 1024 words of 16 bits
  localparam int unsigned PRAM_DEPTH  = 1024;
  localparam int unsigned PRAM_ADDR_W = $clog2(PRAM_DEPTH);

  // Instruction that terminates a program image (also decoded by the processor)
  localparam logic [15:0] PROG_HALT_WORD = 16'h3c00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYTE0,
    ST_BYTE1,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  // Join two stream bytes into one instruction word in the chosen byte order
  function automatic logic [15:0] pair_bytes(input logic [7:0] first_b,
                                             input logic [7:0] second_b,
                                             input logic       msb_first);
    return msb_first ? {first_b, second_b} : {second_b, first_b};
  endfunction

endpackage

// File: rtl/prog_ram_loader_if.sv
// rtl/prog_ram_loader_if.sv - byte stream in and program RAM write port out
interface prog_ram_loader_if
  import prog_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = PRAM_ADDR_W
);

  logic [7:0]        byte_in;
  logic              byte_vld;
  logic              byte_rdy;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;

  // Loader side: consumes bytes, drives the RAM write port
  modport master (
    input  byte_in,
    input  byte_vld,
    output byte_rdy,
    output ram_write_en,
    output ram_addr,
    output ram_din
  );

  // Environment side: byte source plus RAM/observer
  modport slave (
    output byte_in,
    output byte_vld,
    input  byte_rdy,
    input  ram_write_en,
    input  ram_addr,
    input  ram_din
  );

endinterface

// File: rtl/prog_ram_loader.sv
// rtl/prog_ram_loader.sv - pairs stream bytes into words and loads the program RAM
module prog_ram_loader
  import prog_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = PRAM_ADDR_W,
  parameter logic [15:0] HALT_WORD = PROG_HALT_WORD,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  prog_ram_loader_if.master   bus,
  output logic                start,
  output logic                load_err,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        first_q, first_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              accept;

  // byte_rdy is registered and mirrors BYTE0/BYTE1, so this is the handshake
  assign accept = bus.byte_vld & rdy_q;

  // Next-state and datapath: flag outputs are decoded from the next state so
  // they come straight out of flops and track the state register exactly
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d = ST_BYTE0;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_BYTE0: begin
        if (accept) begin
          first_d = bus.byte_in;
          state_d = ST_BYTE1;
        end
      end
      ST_BYTE1: begin
        if (accept) begin
          word_d  = pair_bytes(first_q, bus.byte_in, MSB_FIRST);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (word_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          // RAM is full and no halt arrived; never wrap onto address 0
          state_d = ST_ERR;
        end else begin
          state_d = ST_BYTE0;
          addr_d  = addr_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        if (load_en) begin
          state_d = ST_BYTE0;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d   = (state_d == ST_BYTE0) || (state_d == ST_BYTE1);
    wr_d    = (state_d == ST_WRITE);
    start_d = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  // State, datapath and output registers; reset clears every output at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      first_q <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      first_q <= first_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_rdy     = rdy_q;
  assign bus.ram_write_en = wr_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_din      = word_q;
  assign start            = start_q;
  assign load_err         = err_q;
  assign word_count       = cnt_q;

endmodule

// File: tb/tb_prog_ram_loader.sv
// tb/tb_prog_ram_loader.sv - scoreboard bench for the program RAM loader
module tb_prog_ram_loader;
  import prog_ram_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  b_data;
  logic        b_vld;
  logic        sel;
  logic        load_en_m, load_en_l;
  logic        start_m, err_m, start_l, err_l;
  logic [10:0] cnt_m, cnt_l;
  logic        rdy_sel;

  int tests = 0;
  int fails = 0;
  int nwr_m = 0;
  int nwr_l = 0;
  logic [25:0] exp_m[$];
  logic [25:0] exp_l[$];
  logic [9:0]  ea_m, ea_l;
  logic [25:0] e_m, e_l;

  always #5 clk = ~clk;

  prog_ram_loader_if #(.ADDR_W(10)) ifc_m ();
  prog_ram_loader_if #(.ADDR_W(10)) ifc_l ();

  assign ifc_m.byte_in  = b_data;
  assign ifc_l.byte_in  = b_data;
  assign ifc_m.byte_vld = b_vld & ~sel;
  assign ifc_l.byte_vld = b_vld & sel;
  assign rdy_sel        = sel ? ifc_l.byte_rdy : ifc_m.byte_rdy;

  prog_ram_loader #(.ADDR_W(10), .HALT_WORD(PROG_HALT_WORD), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_en(load_en_m), .bus(ifc_m),
    .start(start_m), .load_err(err_m), .word_count(cnt_m)
  );

  prog_ram_loader #(.ADDR_W(10), .HALT_WORD(PROG_HALT_WORD), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_en(load_en_l), .bus(ifc_l),
    .start(start_l), .load_err(err_l), .word_count(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      b_vld = 1'b0;
      repeat (gap) @(negedge clk);
    end
    b_data = b;
    b_vld  = 1'b1;
    n = 0;
    while (!rdy_sel && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept_in_time", (n < 64), 1);
    @(negedge clk);
    b_vld = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1,
                           input int g0, input int g1);
    if (sel) begin
      exp_l.push_back({ea_l, b1, b0});
      ea_l = ea_l + 1'b1;
    end else begin
      exp_m.push_back({ea_m, b0, b1});
      ea_m = ea_m + 1'b1;
    end
    send_byte(b0, g0);
    send_byte(b1, g1);
  endtask

  task automatic pulse_load(input logic which);
    if (which) load_en_l = 1'b1;
    else       load_en_m = 1'b1;
    @(negedge clk);
    load_en_m = 1'b0;
    load_en_l = 1'b0;
  endtask

  // Write monitor for the MSB-first loader
  always @(negedge clk) begin
    if (ifc_m.ram_write_en === 1'b1) begin
      nwr_m++;
      chk("wr_m_expected", (exp_m.size() > 0), 1);
      if (exp_m.size() > 0) begin
        e_m = exp_m.pop_front();
        chk("wr_m_addr_data", {ifc_m.ram_addr, ifc_m.ram_din}, e_m);
      end
      chk("wr_m_no_accept", ifc_m.byte_rdy, 0);
    end
  end

  // Write monitor for the LSB-first loader
  always @(negedge clk) begin
    if (ifc_l.ram_write_en === 1'b1) begin
      nwr_l++;
      chk("wr_l_expected", (exp_l.size() > 0), 1);
      if (exp_l.size() > 0) begin
        e_l = exp_l.pop_front();
        chk("wr_l_addr_data", {ifc_l.ram_addr, ifc_l.ram_din}, e_l);
      end
      chk("wr_l_no_accept", ifc_l.byte_rdy, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    b_data = 8'h00; b_vld = 1'b0; sel = 1'b0;
    load_en_m = 1'b0; load_en_l = 1'b0;
    ea_m = '0; ea_l = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", ifc_m.byte_rdy, 0);
    chk("rst_wr", ifc_m.ram_write_en, 0);
    chk("rst_start", start_m, 0);
    chk("rst_err", err_m, 0);
    chk("rst_addr", ifc_m.ram_addr, 0);
    chk("rst_din", ifc_m.ram_din, 0);
    chk("rst_cnt", cnt_m, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_not_ready", ifc_m.byte_rdy, 0);

    // MSB-first program ending in halt
    pulse_load(1'b0);
    chk("byte0_ready", ifc_m.byte_rdy, 1);
    send_pair(8'h12, 8'h34, 0, 0);
    send_pair(8'h56, 8'h78, 0, 0);
    send_pair(8'h3c, 8'h00, 0, 0);
    chk("halt_write_cycle", ifc_m.ram_write_en, 1);
    chk("no_start_during_write", start_m, 0);
    @(negedge clk);
    chk("start_after_halt", start_m, 1);
    chk("count_after_halt", cnt_m, 3);
    chk("done_not_ready", ifc_m.byte_rdy, 0);
    chk("queue_empty_1", exp_m.size(), 0);
    repeat (3) @(negedge clk);
    chk("start_held", start_m, 1);
    chk("writes_total_1", nwr_m, 3);

    // Restart from DONE
    pulse_load(1'b0);
    chk("restart_start_low", start_m, 0);
    chk("restart_cnt", cnt_m, 0);
    chk("restart_addr", ifc_m.ram_addr, 0);
    ea_m = '0;
    send_pair(8'hab, 8'hcd, 0, 0);
    @(negedge clk);
    chk("restart_cnt_one", cnt_m, 1);
    chk("restart_next_addr", ifc_m.ram_addr, 1);

    // Reset in BYTE1 after five words
    for (int i = 0; i < 4; i++) send_pair(8'h20 + 8'(i), 8'h40 + 8'(i), 0, 0);
    send_byte(8'h11, 0);
    chk("pre_reset_cnt", cnt_m, 5);
    chk("pre_reset_rdy", ifc_m.byte_rdy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", ifc_m.byte_rdy, 0);
    chk("mid_rst_wr", ifc_m.ram_write_en, 0);
    chk("mid_rst_addr", ifc_m.ram_addr, 0);
    chk("mid_rst_din", ifc_m.ram_din, 0);
    chk("mid_rst_cnt", cnt_m, 0);
    chk("mid_rst_start", start_m, 0);
    chk("mid_rst_err", err_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", ifc_m.byte_rdy, 0);
    chk("queue_empty_2", exp_m.size(), 0);
    ea_m = '0;

    // 2048 zero bytes fill the RAM without a halt
    pulse_load(1'b0);
    w0 = nwr_m;
    for (int i = 0; i < 1024; i++) send_pair(8'h00, 8'h00, 0, 0);
    chk("fill_err_not_yet", err_m, 0);
    @(negedge clk);
    chk("fill_err", err_m, 1);
    chk("fill_start", start_m, 0);
    chk("fill_cnt", cnt_m, 1024);
    chk("fill_writes", nwr_m - w0, 1024);
    repeat (5) @(negedge clk);
    chk("fill_no_more_writes", nwr_m - w0, 1024);
    chk("fill_err_held", err_m, 1);

    // Restart from ERR, then a load with random source gaps
    pulse_load(1'b0);
    chk("err_restart_low", err_m, 0);
    chk("err_restart_cnt", cnt_m, 0);
    ea_m = '0;
    for (int i = 0; i < 5; i++)
      send_pair(8'($urandom_range(8'h40, 8'hff)), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    send_pair(8'h3c, 8'h00, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    @(negedge clk);
    chk("gaps_start", start_m, 1);
    chk("gaps_cnt", cnt_m, 6);
    chk("queue_empty_3", exp_m.size(), 0);

    // LSB-first loader: same stream, no halt recognised
    sel = 1'b1;
    pulse_load(1'b1);
    chk("lsb_ready", ifc_l.byte_rdy, 1);
    send_pair(8'h12, 8'h34, 0, 0);
    send_pair(8'h56, 8'h78, 0, 0);
    send_pair(8'h3c, 8'h00, 0, 0);
    @(negedge clk);
    chk("lsb_no_start", start_l, 0);
    chk("lsb_no_err", err_l, 0);
    chk("lsb_cnt", cnt_l, 3);
    chk("lsb_back_to_byte0", ifc_l.byte_rdy, 1);
    chk("lsb_writes", nwr_l, 3);
    chk("queue_empty_l", exp_l.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
